// File: rtl/packet_out_arbiter_pkg.sv
// Shared state encodings, field widths and sideband type for the packet output arbiter.
// The PKT_ARB_WDOG_EN watchdog is off unless that macro is defined at build time.
package packet_out_arbiter_pkg;

    localparam int WORD_W  = 64;
    localparam int ROUTE_W = 24;
    localparam int NBR_W   = 2;
    localparam int WDOG_W  = 16;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_GRANT   = 2'b01,
        ARB_RELEASE = 2'b10
    } arb_state_t;

    typedef struct packed {
        logic [ROUTE_W-1:0] route;
        logic [NBR_W-1:0]   neighbor;
        logic               bypass;
    } side_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/packet_out_arbiter_if.sv
// Buffer-side handshake plus output link of the packet output arbiter.
// master = arbiter side, slave = buffers and downstream link; wdog_fire exists only with PKT_ARB_WDOG_EN.
interface packet_out_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
);
    import packet_out_arbiter_pkg::*;

    logic [NUM_SRC-1:0]         src_req;
    logic [NUM_SRC-1:0]         src_ack;
    logic [NUM_SRC-1:0]         src_rdy;
    logic [WORD_W*NUM_SRC-1:0]  src_data;
    logic [NUM_SRC-1:0]         src_wr;
    logic [NUM_SRC-1:0]         src_bop;
    logic [NUM_SRC-1:0]         src_eop;
    logic [ROUTE_W*NUM_SRC-1:0] src_pkt_route;
    logic [NBR_W*NUM_SRC-1:0]   src_neighbor;
    logic [NUM_SRC-1:0]         src_bypass;

    logic [WORD_W-1:0]          out_data;
    logic                       out_wr;
    logic                       out_bop;
    logic                       out_eop;
    logic [ROUTE_W-1:0]         out_pkt_route;
    logic [NBR_W-1:0]           out_neighbor;
    logic                       out_bypass;
    logic [SRC_W-1:0]           out_src;
    logic                       out_rdy;
    logic                       out_busy;
`ifdef PKT_ARB_WDOG_EN
    logic                       wdog_fire;
`endif

    modport master (
        input  src_req, src_data, src_wr, src_bop, src_eop,
               src_pkt_route, src_neighbor, src_bypass, out_rdy,
        output src_ack, src_rdy, out_data, out_wr, out_bop, out_eop,
               out_pkt_route, out_neighbor, out_bypass, out_src, out_busy
`ifdef PKT_ARB_WDOG_EN
        , output wdog_fire
`endif
    );

    modport slave (
        output src_req, src_data, src_wr, src_bop, src_eop,
               src_pkt_route, src_neighbor, src_bypass, out_rdy,
        input  src_ack, src_rdy, out_data, out_wr, out_bop, out_eop,
               out_pkt_route, out_neighbor, out_bypass, out_src, out_busy
`ifdef PKT_ARB_WDOG_EN
        , input wdog_fire
`endif
    );

endinterface

// File: rtl/packet_out_arbiter_rr_arbiter.sv
// Purpose: round-robin pick of the first request at or after ptr, wrapping modulo NUM_SRC.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter
    import packet_out_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic               vld,
    output logic [SRC_W-1:0]   idx
);

    logic [SRC_W-1:0] cand;

    // Walk offsets from far to near so the closest requester after ptr wins last.
    always_comb begin
        vld  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            cand = SRC_W'((int'(ptr) + i) % NUM_SRC);
            if (req[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/packet_out_arbiter.sv
// Purpose: round-robin grant of NUM_SRC packet buffers onto one 64-bit link (watchdog under PKT_ARB_WDOG_EN).
// Latency: ack one cycle after req; each granted word appears on out_* one cycle after src_wr.
// Backpressure: src_rdy of the granted buffer follows out_rdy combinationally; words are never dropped.
module packet_out_arbiter
    import packet_out_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    packet_out_arbiter_if.master  bus
);

    if (NUM_SRC < 2 || NUM_SRC > 8 || SRC_W != $clog2(NUM_SRC)) begin : g_bad_src_cfg
        $error("packet_out_arbiter: NUM_SRC must be 2..8 with SRC_W = clog2(NUM_SRC)");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("packet_out_arbiter: TIMEOUT must fit the 16-bit watchdog counter");
    end

    arb_state_t          state;
    logic [SRC_W-1:0]    gnt;
    logic [SRC_W-1:0]    rr_ptr;
    logic [SRC_W-1:0]    pick_idx;
    logic                pick_vld;
    side_t               side_q;
    side_t               lane_side;
    logic [WORD_W-1:0]   lane_data;
    logic                lane_req;
    logic                lane_wr;
    logic                lane_bop;
    logic                lane_eop;
    logic                wdog_hit;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr (
        .req (bus.src_req),
        .ptr (rr_ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    assign lane_req  = bus.src_req[gnt];
    assign lane_wr   = bus.src_wr[gnt];
    assign lane_bop  = bus.src_bop[gnt];
    assign lane_eop  = bus.src_eop[gnt];
    assign lane_data = bus.src_data[int'(gnt)*WORD_W +: WORD_W];
    assign lane_side = '{route:    bus.src_pkt_route[int'(gnt)*ROUTE_W +: ROUTE_W],
                         neighbor: bus.src_neighbor[int'(gnt)*NBR_W +: NBR_W],
                         bypass:   bus.src_bypass[gnt]};

    assign bus.out_pkt_route = side_q.route;
    assign bus.out_neighbor  = side_q.neighbor;
    assign bus.out_bypass    = side_q.bypass;

    always_comb begin
        bus.src_rdy = '0;
        if (state == ARB_GRANT) begin
            bus.src_rdy[gnt] = bus.out_rdy;
        end
    end

`ifdef PKT_ARB_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;
    assign wdog_hit = !lane_wr && (wdog_cnt == WDOG_W'(TIMEOUT - 1));
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ARB_IDLE;
            gnt              <= '0;
            rr_ptr           <= '0;
            side_q           <= '0;
            bus.src_ack      <= '0;
            bus.out_busy     <= 1'b0;
            bus.out_data     <= '0;
            bus.out_wr       <= 1'b0;
            bus.out_bop      <= 1'b0;
            bus.out_eop      <= 1'b0;
            bus.out_src      <= '0;
`ifdef PKT_ARB_WDOG_EN
            wdog_cnt         <= '0;
            bus.wdog_fire    <= 1'b0;
`endif
        end else begin
            bus.out_wr  <= 1'b0;
            bus.out_bop <= 1'b0;
            bus.out_eop <= 1'b0;
`ifdef PKT_ARB_WDOG_EN
            bus.wdog_fire <= 1'b0;
`endif
            case (state)
                ARB_IDLE: begin
                    if (pick_vld) begin
                        gnt          <= pick_idx;
                        bus.src_ack  <= NUM_SRC'(1) << pick_idx;
                        bus.out_busy <= 1'b1;
                        state        <= ARB_GRANT;
`ifdef PKT_ARB_WDOG_EN
                        wdog_cnt     <= '0;
`endif
                    end
                end
                ARB_GRANT: begin
                    // A word written alongside the falling request is still forwarded.
                    if (lane_wr) begin
                        bus.out_data <= lane_data;
                        bus.out_wr   <= 1'b1;
                        bus.out_bop  <= lane_bop;
                        bus.out_eop  <= lane_eop;
                        if (lane_bop) begin
                            side_q      <= lane_side;
                            bus.out_src <= gnt;
                        end
                    end
`ifdef PKT_ARB_WDOG_EN
                    wdog_cnt <= lane_wr ? '0 : wdog_cnt + WDOG_W'(1);
                    if (wdog_hit) begin
                        bus.wdog_fire <= 1'b1;
                        bus.out_eop   <= 1'b1;
                    end
`endif
                    if (!lane_req || wdog_hit) begin
                        bus.src_ack  <= '0;
                        bus.out_busy <= 1'b0;
                        state        <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    rr_ptr <= SRC_W'(wrap_inc(int'(gnt), NUM_SRC));
                    state  <= ARB_IDLE;
                end
                default: begin
                    bus.src_ack  <= '0;
                    bus.out_busy <= 1'b0;
                    state        <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_out_arbiter.sv
// Directed and randomized packet traffic against a transaction-level round-robin model.
module tb_packet_out_arbiter;
    import packet_out_arbiter_pkg::*;

    localparam int NS = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   ptr_m   = 0;
    bit   rel_pending = 1'b0;
    int   last_w  = -1;

    packet_out_arbiter_if #(.NUM_SRC(NS), .SRC_W(SW)) bus();

    packet_out_arbiter #(.NUM_SRC(NS), .SRC_W(SW), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Winner = requester with the smallest cyclic distance from the pointer.
    function automatic int model_winner(input logic [NS-1:0] rq);
        int best  = -1;
        int bestd = NS;
        for (int i = 0; i < NS; i++) begin
            if (rq[i] && ((i - ptr_m + NS) % NS) < bestd) begin
                bestd = (i - ptr_m + NS) % NS;
                best  = i;
            end
        end
        return best;
    endfunction

    always @(negedge clk) begin
        if (!reset) check("ack_onehot0", 64'($onehot0(bus.src_ack)), 64'(1));
    end

    // mode 0: fixed words 0x11,0x22,.. with rdy=1; mode 1: random rdy/writes; mode 2: rdy 1,0,0,1,1..
    task automatic run_packet(input int n, input int mode, input int abort_after);
        int w, sent, cyc;
        logic rdy, wr, drop, byp;
        logic [63:0] word, exp_rdy;
        logic [23:0] r;
        logic [1:0]  nb;
        if (rel_pending) begin
            step();
            check("gap_ack", 64'(bus.src_ack), 64'(0));
            check("gap_wr", 64'(bus.out_wr), 64'(0));
            rel_pending = 1'b0;
        end
        w = model_winner(bus.src_req);
        last_w = w;
        step();
        check("grant_ack", 64'(bus.src_ack), 64'(1) << w);
        check("grant_busy", 64'(bus.out_busy), 64'(1));
        if (mode == 0) begin
            r = 24'h00000A; nb = 2'd1; byp = 1'b0;
        end else begin
            r = 24'($urandom); nb = 2'($urandom); byp = 1'($urandom);
        end
        bus.src_pkt_route[w*24 +: 24] = r;
        bus.src_neighbor[w*2 +: 2]    = nb;
        bus.src_bypass[w]             = byp;
        sent = 0; cyc = 0; drop = 1'b0;
        while (sent < n && cyc < 64) begin
            case (mode)
                1:       rdy = 1'($urandom);
                2:       rdy = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
                default: rdy = 1'b1;
            endcase
            bus.out_rdy = rdy;
            #1;
            exp_rdy = rdy ? (64'(1) << w) : 64'(0);
            check("src_rdy", 64'(bus.src_rdy), exp_rdy);
            wr = (mode == 1) ? (rdy ? ($urandom % 4 != 0) : ($urandom % 8 == 0)) : rdy;
            if (wr) begin
                word = (mode == 0) ? 64'h11 * 64'(sent + 1) : {$urandom, $urandom};
                bus.src_data[w*64 +: 64] = word;
                bus.src_wr[w]  = 1'b1;
                bus.src_bop[w] = (sent == 0);
                bus.src_eop[w] = (sent == n - 1);
                if (sent == n - 1 && $urandom % 2 == 1) begin
                    bus.src_req[w] = 1'b0;
                    drop = 1'b1;
                end
            end
            step();
            bus.src_wr[w] = 1'b0; bus.src_bop[w] = 1'b0; bus.src_eop[w] = 1'b0;
            check("out_wr", 64'(bus.out_wr), 64'(wr));
            if (wr) begin
                check("out_data", bus.out_data, word);
                check("out_bop", 64'(bus.out_bop), 64'(sent == 0));
                check("out_eop", 64'(bus.out_eop), 64'(sent == n - 1));
                check("out_route", 64'(bus.out_pkt_route), 64'(r));
                check("out_neighbor", 64'(bus.out_neighbor), 64'(nb));
                check("out_bypass", 64'(bus.out_bypass), 64'(byp));
                check("out_src", 64'(bus.out_src), 64'(w));
                sent++;
            end
            cyc++;
            if (abort_after >= 0 && sent == abort_after) return;
        end
        check("words_forwarded", 64'(sent), 64'(n));
        if (!drop) begin
            bus.src_req[w] = 1'b0;
            step();
            check("post_eop_wr", 64'(bus.out_wr), 64'(0));
        end
        check("release_ack", 64'(bus.src_ack), 64'(0));
        check("release_busy", 64'(bus.out_busy), 64'(0));
        ptr_m = (w + 1) % NS;
        rel_pending = 1'b1;
    endtask

    initial begin : stim
        reset = 1'b1;
        bus.src_req = '0; bus.src_data = '0; bus.src_wr = '0; bus.src_bop = '0; bus.src_eop = '0;
        bus.src_pkt_route = '0; bus.src_neighbor = '0; bus.src_bypass = '0; bus.out_rdy = 1'b0;
        #12;
        check("rst_ack", 64'(bus.src_ack), 64'(0));
        check("rst_wr", 64'(bus.out_wr), 64'(0));
        check("rst_data", bus.out_data, 64'(0));
        check("rst_busy", 64'(bus.out_busy), 64'(0));
        check("rst_src", 64'(bus.out_src), 64'(0));
        check("rst_rdy", 64'(bus.src_rdy), 64'(0));
        reset = 1'b0;
        step();

        // Round robin with every buffer requesting: 0,1,2,3,0.
        bus.src_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_packet(2, 0, -1);
            check("rr_order", 64'(last_w), 64'(k % NS));
            bus.src_req = 4'b1111;
        end

        // Lone source 2 sending 0x11,0x22,0x33.
        bus.src_req = 4'b0100;
        run_packet(3, 0, -1);
        check("single_src", 64'(last_w), 64'(2));
        check("single_nbr", 64'(bus.out_neighbor), 64'(1));

        // Release spacing: source 1 re-requests immediately, source 3 must go first.
        bus.src_req = 4'b0001;
        run_packet(1, 0, -1);
        bus.src_req = 4'b1010;
        run_packet(2, 0, -1);
        check("spacing_first", 64'(last_w), 64'(1));
        bus.src_req[1] = 1'b1;
        run_packet(2, 0, -1);
        check("spacing_second", 64'(last_w), 64'(3));
        run_packet(1, 0, -1);
        check("spacing_third", 64'(last_w), 64'(1));

        // Backpressure with out_rdy 1,0,0,1 across a 4-word packet.
        bus.src_req = 4'b0100;
        run_packet(4, 2, -1);

        for (int k = 0; k < 10; k++) begin
            bus.src_req = 4'($urandom_range(1, 15));
            run_packet($urandom_range(1, 5), 1, -1);
        end

        // Reset after word 2 of 5 from source 2.
        bus.src_req = 4'b0100;
        run_packet(5, 0, 2);
        reset = 1'b1;
        #1;
        check("mid_rst_ack", 64'(bus.src_ack), 64'(0));
        check("mid_rst_wr", 64'(bus.out_wr), 64'(0));
        check("mid_rst_data", bus.out_data, 64'(0));
        check("mid_rst_busy", 64'(bus.out_busy), 64'(0));
        check("mid_rst_route", 64'(bus.out_pkt_route), 64'(0));
        check("mid_rst_rdy", 64'(bus.src_rdy), 64'(0));
        bus.src_req = '0; bus.src_wr = '0; bus.src_bop = '0; bus.src_eop = '0;
        step();
        reset = 1'b0;
        ptr_m = 0;
        rel_pending = 1'b0;
        bus.src_req = 4'b1111;
        run_packet(1, 0, -1);
        check("post_rst_ptr", 64'(last_w), 64'(0));

`ifdef PKT_ARB_WDOG_EN
        begin : wdog_test
            int w, fire_cyc;
            bus.src_req = 4'b1010;
            if (rel_pending) begin
                step();
                rel_pending = 1'b0;
            end
            w = model_winner(bus.src_req);
            step();
            check("wdog_grant", 64'(bus.src_ack), 64'(1) << w);
            fire_cyc = -1;
            for (int k = 1; k <= 40 && fire_cyc < 0; k++) begin
                step();
                if (bus.wdog_fire) fire_cyc = k;
            end
            check("wdog_cycle", 64'(fire_cyc), 64'(16));
            check("wdog_eop", 64'(bus.out_eop), 64'(1));
            check("wdog_wr", 64'(bus.out_wr), 64'(0));
            check("wdog_ack", 64'(bus.src_ack), 64'(0));
            ptr_m = (w + 1) % NS;
            step();
            step();
            check("wdog_next_grant", 64'(bus.src_ack), 64'(1) << model_winner(bus.src_req));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/packet_out_arbiter.md
Name: packet_out_arbiter

Overview:
- Sits directly downstream of up to NUM_SRC packet buffer stages (bypass or normal).
- Arbitrates their req/ack handshake round-robin and forwards the granted buffer's packet words onto a single 64-bit output link.
- Carries route, neighbor and bypass sideband alongside the data.
- Output is registered: one word per cycle while the downstream link is ready.

Parameters:
- NUM_SRC, 4, number of upstream buffers (2..8)
- SRC_W, 2, index width, equal to clog2(NUM_SRC)
- TIMEOUT, 1024, watchdog limit in cycles (used only with PKT_ARB_WDOG_EN)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- src_req  in  NUM_SRC  per-buffer send request
- src_ack  out  NUM_SRC  per-buffer grant, one-hot or zero
- src_rdy  out  NUM_SRC  per-buffer read enable
- src_data  in  64*NUM_SRC  packet words, buffer i at [64i+63:64i]
- src_wr  in  NUM_SRC  word-valid strobes
- src_bop  in  NUM_SRC  first-word flags
- src_eop  in  NUM_SRC  last-word flags
- src_pkt_route  in  24*NUM_SRC  remaining route field
- src_neighbor  in  2*NUM_SRC  next-hop neighbor index
- src_bypass  in  NUM_SRC  bypass flag
- out_data  out  64  forwarded word
- out_wr  out  1  forwarded word valid
- out_bop  out  1  first word of packet
- out_eop  out  1  last word of packet
- out_pkt_route  out  24  route, latched at bop
- out_neighbor  out  2  neighbor, latched at bop
- out_bypass  out  1  bypass, latched at bop
- out_src  out  SRC_W  index of the granted source
- out_rdy  in  1  downstream can accept a word this cycle
- out_busy  out  1  a grant is active

Behaviour:
- Reset (asynchronous, active-high): state=ARB_IDLE, rr_ptr=0, all outputs 0.
- States: ARB_IDLE, ARB_GRANT, ARB_RELEASE.
- ARB_IDLE:
  - Search src_req starting at rr_ptr, wrapping modulo NUM_SRC.
  - On a hit at index g, register gnt=g, assert src_ack[g] from the next cycle, then go to ARB_GRANT.
  - No request: remain in ARB_IDLE, src_ack=0.
- ARB_GRANT:
  - src_ack[gnt]=1; out_busy=1.
  - src_rdy[gnt]=out_rdy, combinational; all other src_rdy bits are 0.
  - When src_wr[gnt] is high: out_data, out_bop and out_eop take the granted lane on the next edge, and out_wr=1 for exactly one cycle (latency 1).
  - When src_wr[gnt] is low: out_wr=0 and out_data holds its last value.
  - On src_wr&src_bop: latch out_pkt_route, out_neighbor, out_bypass and out_src from the gnt lane; these hold until the next bop.
  - A word with src_wr high while out_rdy is low is still forwarded. Buffers only write when rdy is high, so this only indicates a protocol violation and is not dropped.
  - Leave ARB_GRANT when src_req[gnt] falls (the buffer has finished its packet and entered its cancel state): go to ARB_RELEASE.
- ARB_RELEASE:
  - src_ack=0 for one cycle; rr_ptr = gnt+1 mod NUM_SRC; then go to ARB_IDLE.
  - This guarantees the buffer sees ack low before it can re-request.
- Fairness: a source that has just been served has the lowest priority next round. Worst-case wait for any requester is NUM_SRC-1 packets.
- Simultaneous events:
  - A new request from another source during ARB_GRANT is ignored until ARB_IDLE.
  - If src_req[gnt] falls in the same cycle as a src_wr, that word is still forwarded.
- Words without bop before eop are forwarded unchanged; sideband keeps its previous value.
- Reset mid-packet: outputs clear immediately and src_ack drops. The buffer recovers through its own reset.

Optional Feature:
- Macro: PKT_ARB_WDOG_EN.
- Defined:
  - A 16-bit counter clears on every src_wr in ARB_GRANT and increments otherwise.
  - Reaching TIMEOUT forces ARB_RELEASE, pulses output wdog_fire (1 cycle, extra port), and emits a synthetic out_eop with out_wr=0.
  - rr_ptr advances past the stalled source.
- Undefined: no counter, no wdog_fire port; a stalled grant waits forever.

Decomposition:
- Shared package/defines header holds:
  - state encodings ARB_IDLE=2'b00, ARB_GRANT=2'b01, ARB_RELEASE=2'b10;
  - word width 64 and route width 24 constants;
  - PKT_ARB_WDOG_EN default (off).
- One sub-module: rr_arbiter. It is purely combinational, taking NUM_SRC req bits and rr_ptr, and returning a valid flag plus the grant index. It is reused by the input-side dispatcher.

Test Plan:
- Single source:
  - Stimulus: src_req[2] high; buffer 2 sends 3 words 0x11,0x22,0x33 with bop on the first word and eop on the third; route=0x00000A, neighbor=1; out_rdy=1.
  - Response: src_ack[2] rises one cycle after req; out_wr pulses on 3 consecutive cycles, each 1 cycle after src_wr; out_bop on word 0x11, out_eop on 0x33; out_neighbor=1; out_src=2; ack falls one cycle after req falls.
- Round-robin:
  - Stimulus: src_req=4'b1111 held, each buffer sends a 2-word packet.
  - Response: grant order 0,1,2,3,0; exactly one ack bit high at any time.
- Backpressure:
  - Stimulus: out_rdy toggled 1,0,0,1 during a 4-word packet.
  - Response: src_rdy[gnt] mirrors out_rdy; all 4 words appear in order with no duplicates.
- Release spacing:
  - Stimulus: source 1 drops req and re-asserts it immediately; source 3 is requesting.
  - Response: ack low for at least 1 cycle; source 3 is granted before source 1.
- Reset mid-packet:
  - Stimulus: assert reset after word 2 of 5.
  - Response: all outputs are 0 in the same cycle; after release, the arbiter is in ARB_IDLE and rr_ptr=0.
- Watchdog (PKT_ARB_WDOG_EN defined, TIMEOUT=16):
  - Stimulus: granted source asserts req but never writes.
  - Response: wdog_fire pulses in cycle 16 and the next requester is granted.
